// File: rtl/gray_conv_pipe.sv
// gray_conv_pipe: pipelined binary<->Gray converter with valid/ready handshakes.
// The direction is chosen per word by in_mode: 0 = binary-to-Gray, 1 = Gray-to-binary.
// Binary-to-Gray is finished in stage 1. Gray-to-binary resolves one MSB-first slice
// of ceil(WIDTH/STAGES) bits per stage. The partially resolved word is carried
// between stages, so each slice can start from the bit above it.
// Optional build macro CONV_PARITY_EN adds out_parity, the XOR reduction of out_data.
module gray_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
`ifdef CONV_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

    // Resolve the Gray bits that belong to slice `stage` (0-based, MSB-first).
    // Bits above the slice are already binary, so the descending walk can chain
    // each bit off the one above it.
    function automatic logic [WIDTH-1:0] resolve_slice(input logic [WIDTH-1:0] word,
                                                       input int stage);
        logic [WIDTH-1:0] w;
        w = word;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if ((WIDTH - 1 - i) / SLICE == stage) begin
                w[i] = w[i+1] ^ w[i];
            end
        end
        return w;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_mode;
    logic [WIDTH-1:0]  r_data [STAGES];

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_up_v;
    logic [STAGES-1:0] w_up_mode;
    logic [WIDTH-1:0]  w_up_data [STAGES];

    // Ready chain: a stage may load when it is empty or when the stage below it moves.
    always_comb begin
        logic l_adv;
        l_adv = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            l_adv    = !r_v[k] || l_adv;
            w_adv[k] = l_adv;
        end
    end

    // Values offered to each stage: conversion work for that stage applied to its upstream word.
    always_comb begin
        w_up_v[0]    = in_valid;
        w_up_mode[0] = in_mode;
        w_up_data[0] = in_mode ? resolve_slice(in_data, 0) : (in_data ^ (in_data >> 1));
        for (int k = 1; k < STAGES; k++) begin
            w_up_v[k]    = r_v[k-1];
            w_up_mode[k] = r_mode[k-1];
            w_up_data[k] = r_mode[k-1] ? resolve_slice(r_data[k-1], k) : r_data[k-1];
        end
    end

    // Stage registers: load on advance, hold otherwise; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_mode <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k]    <= w_up_v[k];
                    r_mode[k] <= w_up_mode[k];
                    r_data[k] <= w_up_data[k];
                end
            end
        end
    end

`ifdef CONV_PARITY_EN
    logic r_parity;

    // Parity is registered alongside the last stage so that it holds with out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_adv[STAGES-1]) begin
            r_parity <= ^w_up_data[STAGES-1];
        end
    end

    assign out_parity = r_parity;
`endif

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_mode  = r_mode[STAGES-1];

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Testbench for gray_conv_pipe: a scoreboard against a reference queue, plus directed
// literal vectors. It also checks the latency for WIDTH=5 with several STAGES values.
module tb_gray_conv_pipe;

    localparam int W  = 8;
    localparam int ST = 2;
    localparam int SW_ST [4] = '{1, 2, 3, 5};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
`ifdef CONV_PARITY_EN
    logic         out_parity;
`endif

    logic         s_in_valid  [4];
    logic         s_in_ready  [4];
    logic [4:0]   s_in_data   [4];
    logic         s_out_valid [4];
    logic [4:0]   s_out_data  [4];
    logic         s_out_mode  [4];
`ifdef CONV_PARITY_EN
    logic         s_out_parity [4];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int out_count = 0;

    typedef struct packed {
        logic         mode;
        logic [W-1:0] data;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    gray_conv_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
`ifdef CONV_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    for (genvar j = 0; j < 4; j++) begin : g_sweep
        gray_conv_pipe #(.WIDTH(5), .STAGES(SW_ST[j])) dut_s (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s_in_valid[j]),
            .in_ready  (s_in_ready[j]),
            .in_mode   (1'b1),
            .in_data   (s_in_data[j]),
            .out_valid (s_out_valid[j]),
            .out_ready (1'b1),
            .out_data  (s_out_data[j]),
            .out_mode  (s_out_mode[j])
`ifdef CONV_PARITY_EN
            ,
            .out_parity(s_out_parity[j])
`endif
        );
    end

    // Reference conversions, written as whole-word arithmetic.
    function automatic logic [W-1:0] model_conv(input logic mode, input logic [W-1:0] d);
        logic [W-1:0] r;
        if (!mode) begin
            r = d ^ (d >> 1);
        end else begin
            r = d;
            for (int s = 1; s < W; s++) r = r ^ (d >> s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled mid-cycle, against the transfers the next rising edge will perform.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_mode;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == ST && !out_ready)});
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {56'd0, out_data}, {56'd0, prev_data});
                chk("stall_mode", {63'd0, out_mode}, {63'd0, prev_mode});
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (q.size() == 0) begin
                    chk("unexpected_output", {56'd0, out_data}, 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", {56'd0, out_data}, {56'd0, e.data});
                    chk("sb_mode", {63'd0, out_mode}, {63'd0, e.mode});
`ifdef CONV_PARITY_EN
                    chk("sb_parity", {63'd0, out_parity}, {63'd0, ^e.data});
`endif
                end
            end
            if (in_valid && in_ready) begin
                e.mode = in_mode;
                e.data = model_conv(in_mode, in_data);
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_mode  = out_mode;
        end
    end

    task automatic send_one(input logic m, input logic [W-1:0] d, input logic [W-1:0] expd,
                            input string name);
        int lat;
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_latency"}, 64'(lat), 64'(ST));
        chk({name, "_data"}, {56'd0, out_data}, {56'd0, expd});
        chk({name, "_mode"}, {63'd0, out_mode}, {63'd0, m});
`ifdef CONV_PARITY_EN
        if (d == 8'hEF && m) chk({name, "_parity"}, {63'd0, out_parity}, 64'd1);
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int oc;
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            s_in_valid[j] = 1'b0;
            s_in_data[j]  = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_out_mode", {63'd0, out_mode}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef CONV_PARITY_EN
        chk("rst_out_parity", {63'd0, out_parity}, 64'd0);
`endif

        send_one(1'b0, 8'hB5, 8'hEF, "b2g_B5");
        send_one(1'b1, 8'hEF, 8'hB5, "g2b_EF");
        send_one(1'b1, 8'h80, 8'hFF, "g2b_80");
        send_one(1'b0, 8'hFF, 8'h80, "b2g_FF");

        // Back-to-back sweep over every code, alternating direction each word.
        oc = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_mode  = i[0];
            in_data  = i[7:0];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("sweep_count", 64'(out_count - oc), 64'd256);

        // Random backpressure with a continuous input stream.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'b1;
            in_mode   = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("random_drained", 64'(q.size()), 64'd0);

        // Fill the pipe, then reset while a new word is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 8'h3C;
        for (int i = 0; i < 3; i++) tick();
        chk("full_valid", {63'd0, out_valid}, 64'd1);
        in_data = 8'hAA;
        rst     = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        oc = out_count;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_no_output", 64'(out_count - oc), 64'd0);
        chk("midrst_valid_low", {63'd0, out_valid}, 64'd0);

        // WIDTH=5 latency sweep on Gray 0x1F.
        for (int j = 0; j < 4; j++) begin
            chk("sweep5_in_ready", {63'd0, s_in_ready[j]}, 64'd1);
            s_in_valid[j] = 1'b1;
            s_in_data[j]  = 5'h1F;
            tick();
            s_in_valid[j] = 1'b0;
            lat = 1;
            while (!s_out_valid[j] && lat < 20) begin
                tick();
                lat++;
            end
            chk("sweep5_latency", 64'(lat), 64'(SW_ST[j]));
            chk("sweep5_data", {59'd0, s_out_data[j]}, 64'h15);
            chk("sweep5_mode", {63'd0, s_out_mode[j]}, 64'd1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
